// File: rtl/sevenseg_pkg.sv
// Shared constants, FSM state type and segment encoder for the serial seven-segment driver.
package sevenseg_pkg;

    localparam logic [7:0] CMD_DATA_AUTOINC = 8'h40;
    localparam logic [7:0] CMD_ADDR0        = 8'hC0;
    localparam logic [7:0] CMD_DISP         = 8'h80;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        T1_SEND = 3'd1,
        T1_END  = 3'd2,
        T2_SEND = 3'd3,
        T2_END  = 3'd4,
        T3_SEND = 3'd5,
        T3_END  = 3'd6,
        DONE    = 3'd7
    } state_t;

    // Hex nibble to segment pattern, bit order gfedcba.
    function automatic logic [6:0] seg_encode(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            4'hF:    seg = 7'h71;
            default: seg = 7'h00;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/sevenseg_snapshot.sv
// Captures display inputs at frame start and holds the encoded digit bytes and display command.
// Build option LEADING_ZERO_BLANK_EN blanks zero digits above the highest non-zero digit.
module sevenseg_snapshot
    import sevenseg_pkg::*;
#(
    parameter int NUM_SEGS   = 4,
    parameter int DIGIT_BITS = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         load,
    input  logic [NUM_SEGS*DIGIT_BITS-1:0] digits,
    input  logic [NUM_SEGS-1:0]          dp,
    input  logic [2:0]                   brightness,
    input  logic                         display_on,
    output logic [NUM_SEGS*8-1:0]        seg_bytes,
    output logic [7:0]                   disp_cmd
);

    logic [NUM_SEGS-1:0]   blank_s;
    logic [NUM_SEGS*8-1:0] enc_s;

`ifdef LEADING_ZERO_BLANK_EN
    logic seen_s;

    // Mark leading zero digits, scanning from the most significant; digit 0 always shows.
    always_comb begin
        blank_s = '0;
        seen_s  = 1'b0;
        for (int k = NUM_SEGS - 1; k > 0; k--) begin
            if (digits[k*DIGIT_BITS +: 4] != 4'h0) begin
                seen_s = 1'b1;
            end else begin
                seen_s = seen_s;
            end
            blank_s[k] = ~seen_s;
        end
    end
`else
    // No blanking in this build.
    always_comb begin
        blank_s = '0;
    end
`endif

    // Encode every digit; the decimal point survives blanking.
    always_comb begin
        enc_s = '0;
        for (int k = 0; k < NUM_SEGS; k++) begin
            enc_s[k*8 +: 8] = {dp[k], blank_s[k] ? 7'h00 : seg_encode(digits[k*DIGIT_BITS +: 4])};
        end
    end

    // Snapshot registers, written only when a frame starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_bytes <= '0;
            disp_cmd  <= 8'h00;
        end else if (load) begin
            seg_bytes <= enc_s;
            disp_cmd  <= CMD_DISP | {4'b0000, display_on, brightness};
        end else begin
            seg_bytes <= seg_bytes;
            disp_cmd  <= disp_cmd;
        end
    end

endmodule

// File: rtl/sevenseg_serial_multi.sv
// Periodic refresh driver for TM1637-style displays: three serial_2wire transactions per frame.
// Build option LEADING_ZERO_BLANK_EN is handled inside sevenseg_snapshot.
module sevenseg_serial_multi
    import sevenseg_pkg::*;
#(
    parameter int MAIN_CLK   = 27_000_000,
    parameter int UPDATE_HZ  = 20,
    parameter int BUS_BITS   = 8,
    parameter int NUM_SEGS   = 4,
    parameter int DIGIT_BITS = 4
) (
    input  logic                           in_clk,
    input  logic                           in_rst_n,
    input  logic                           in_update,
    input  logic [NUM_SEGS*DIGIT_BITS-1:0] in_digits,
    input  logic [NUM_SEGS-1:0]            in_dp,
    input  logic [2:0]                     in_brightness,
    input  logic                           in_display_on,
    input  logic                           in_bus_ready,
    input  logic                           in_bus_next_word,
    output logic                           out_bus_enable,
    output logic [BUS_BITS-1:0]            out_bus_data,
    output logic                           out_busy,
    output logic                           out_frame_done
);

    localparam int PERIOD = MAIN_CLK / UPDATE_HZ;
    localparam int TMR_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int IDX_W  = $clog2(NUM_SEGS + 2);
    localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(PERIOD - 1);
    localparam logic [IDX_W-1:0] T2_LAST    = IDX_W'(NUM_SEGS);

    state_t                state_r;
    logic [IDX_W-1:0]      idx_r;
    logic [IDX_W-1:0]      idx_next_s;
    logic [TMR_W-1:0]      timer_r;
    logic                  start_s;
    logic [7:0]            t2_word_s;
    logic [NUM_SEGS*8-1:0] seg_bytes_s;
    logic [7:0]            disp_cmd_s;

    sevenseg_snapshot #(
        .NUM_SEGS   (NUM_SEGS),
        .DIGIT_BITS (DIGIT_BITS)
    ) u_snapshot (
        .clk        (in_clk),
        .rst_n      (in_rst_n),
        .load       (start_s),
        .digits     (in_digits),
        .dp         (in_dp),
        .brightness (in_brightness),
        .display_on (in_display_on),
        .seg_bytes  (seg_bytes_s),
        .disp_cmd   (disp_cmd_s)
    );

    // Frame start: idle, refresh period elapsed, refresh allowed and bus free.
    always_comb begin
        start_s = (state_r == IDLE) && (timer_r == '0) && in_update && in_bus_ready;
    end

    // Next T2 word: index 1 carries the most significant digit.
    always_comb begin
        idx_next_s = idx_r + IDX_W'(1);
        t2_word_s  = CMD_ADDR0;
        for (int k = 0; k < NUM_SEGS; k++) begin
            if (idx_next_s == IDX_W'(NUM_SEGS - k)) begin
                t2_word_s = seg_bytes_s[k*8 +: 8];
            end else begin
                t2_word_s = t2_word_s;
            end
        end
    end

    // Refresh timer; holds at zero ("expired") so an overrun frame starts as soon as possible.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            timer_r <= '0;
        end else if (start_s) begin
            timer_r <= TMR_RELOAD;
        end else if (timer_r != '0) begin
            timer_r <= timer_r - TMR_W'(1);
        end else begin
            timer_r <= timer_r;
        end
    end

    // Frame sequencer with registered bus and status outputs.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_r        <= IDLE;
            idx_r          <= '0;
            out_bus_enable <= 1'b0;
            out_bus_data   <= '0;
            out_busy       <= 1'b0;
            out_frame_done <= 1'b0;
        end else begin
            out_frame_done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start_s) begin
                        state_r        <= T1_SEND;
                        idx_r          <= '0;
                        out_busy       <= 1'b1;
                        out_bus_enable <= 1'b1;
                        out_bus_data   <= BUS_BITS'(CMD_DATA_AUTOINC);
                    end
                end
                T1_SEND: begin
                    if (in_bus_next_word) begin
                        state_r        <= T1_END;
                        out_bus_enable <= 1'b0;
                    end
                end
                T1_END: begin
                    if (in_bus_ready) begin
                        state_r        <= T2_SEND;
                        idx_r          <= '0;
                        out_bus_enable <= 1'b1;
                        out_bus_data   <= BUS_BITS'(CMD_ADDR0);
                    end
                end
                T2_SEND: begin
                    if (in_bus_next_word) begin
                        if (idx_r == T2_LAST) begin
                            state_r        <= T2_END;
                            out_bus_enable <= 1'b0;
                        end else begin
                            idx_r        <= idx_next_s;
                            out_bus_data <= BUS_BITS'(t2_word_s);
                        end
                    end
                end
                T2_END: begin
                    if (in_bus_ready) begin
                        state_r        <= T3_SEND;
                        idx_r          <= '0;
                        out_bus_enable <= 1'b1;
                        out_bus_data   <= BUS_BITS'(disp_cmd_s);
                    end
                end
                T3_SEND: begin
                    if (in_bus_next_word) begin
                        state_r        <= T3_END;
                        out_bus_enable <= 1'b0;
                    end
                end
                T3_END: begin
                    if (in_bus_ready) begin
                        state_r        <= DONE;
                        out_busy       <= 1'b0;
                        out_frame_done <= 1'b1;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r        <= IDLE;
                    out_bus_enable <= 1'b0;
                    out_busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sevenseg_serial_multi.sv
// Directed bench for sevenseg_serial_multi with a simple serial_2wire bus model.
module tb_sevenseg_serial_multi;

    localparam int NS     = 4;
    localparam int PERIOD = 100;
`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic          in_clk = 1'b0;
    logic          in_rst_n;
    logic          in_update;
    logic [15:0]   in_digits;
    logic [NS-1:0] in_dp;
    logic [2:0]    in_brightness;
    logic          in_display_on;
    logic          in_bus_ready;
    logic          in_bus_next_word;
    logic          out_bus_enable;
    logic [7:0]    out_bus_data;
    logic          out_busy;
    logic          out_frame_done;

    always #5 in_clk = ~in_clk;

    sevenseg_serial_multi #(
        .MAIN_CLK   (1000),
        .UPDATE_HZ  (10),
        .BUS_BITS   (8),
        .NUM_SEGS   (NS),
        .DIGIT_BITS (4)
    ) dut (
        .in_clk           (in_clk),
        .in_rst_n         (in_rst_n),
        .in_update        (in_update),
        .in_digits        (in_digits),
        .in_dp            (in_dp),
        .in_brightness    (in_brightness),
        .in_display_on    (in_display_on),
        .in_bus_ready     (in_bus_ready),
        .in_bus_next_word (in_bus_next_word),
        .out_bus_enable   (out_bus_enable),
        .out_bus_data     (out_bus_data),
        .out_busy         (out_busy),
        .out_frame_done   (out_frame_done)
    );

    typedef struct {
        logic [15:0] digits;
        logic [3:0]  dp;
        logic [2:0]  br;
        logic        disp_on;
        logic [55:0] words;
    } vec_t;

    vec_t       vecs [6];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] log_q [$];
    int         bus_delay = 2;
    bit         bus_busy = 1'b0;
    int         bus_cnt = 0;
    int         bus_tail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Bus model: latches each word after bus_delay cycles, ready returns 2 cycles after enable drops.
    initial begin
        in_bus_ready     = 1'b1;
        in_bus_next_word = 1'b0;
        forever begin
            @(negedge in_clk);
            in_bus_next_word = 1'b0;
            if (!bus_busy) begin
                if (out_bus_enable) begin
                    bus_busy     = 1'b1;
                    in_bus_ready = 1'b0;
                    bus_cnt      = 0;
                    bus_tail     = 0;
                end
            end else if (out_bus_enable) begin
                bus_cnt++;
                if (bus_cnt >= bus_delay) begin
                    log_q.push_back(out_bus_data);
                    in_bus_next_word = 1'b1;
                    bus_cnt          = 0;
                end
            end else begin
                bus_tail++;
                if (bus_tail >= 2) begin
                    in_bus_ready = 1'b1;
                    bus_busy     = 1'b0;
                end
            end
        end
    end

    task automatic apply(input vec_t v);
        in_digits     = v.digits;
        in_dp         = v.dp;
        in_brightness = v.br;
        in_display_on = v.disp_on;
    endtask

    task automatic wait_done(input int budget, output int starts, output int first_rise, output bit seen);
        logic prev;
        prev       = out_busy;
        starts     = 0;
        first_rise = -1;
        seen       = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge in_clk);
            if (out_busy && !prev) begin
                starts++;
                if (first_rise < 0) first_rise = i;
            end
            prev = out_busy;
            if (out_frame_done) seen = 1'b1;
        end
    endtask

    task automatic wait_log(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge in_clk);
            if (log_q.size() >= n) ok = 1'b1;
        end
    endtask

    task automatic check_frame(input string tag, input logic [55:0] exp);
        logic [7:0] e;
        check({tag, "_words"}, log_q.size(), 7);
        for (int j = 0; j < 7 && j < log_q.size(); j++) begin
            e = exp[8*(6-j) +: 8];
            check($sformatf("%s_w%0d", tag, j), log_q[j], e);
        end
    endtask

    initial begin
        int   starts;
        int   first_rise;
        int   en_cnt;
        bit   seen;
        bit   ok;
        vec_t tear;

        vecs[0] = '{16'h12AF, 4'b0000, 3'd7, 1'b1, 56'h40_C0_06_5B_77_71_8F};
        vecs[1] = '{16'h0030, 4'b0100, 3'd3, 1'b1,
                    {8'h40, 8'hC0, LZB ? 8'h00 : 8'h3F, LZB ? 8'h80 : 8'hBF, 8'h4F, 8'h3F, 8'h8B}};
        vecs[2] = '{16'h0000, 4'b1111, 3'd0, 1'b0,
                    {8'h40, 8'hC0, LZB ? 8'h80 : 8'hBF, LZB ? 8'h80 : 8'hBF, LZB ? 8'h80 : 8'hBF, 8'hBF, 8'h80}};
        vecs[3] = '{16'h8E5D, 4'b0001, 3'd5, 1'b1, 56'h40_C0_7F_79_6D_DE_8D};
        vecs[4] = '{16'h9C64, 4'b1000, 3'd1, 1'b0, 56'h40_C0_EF_39_7D_66_81};
        vecs[5] = '{16'h0B07, 4'b0010, 3'd6, 1'b1,
                    {8'h40, 8'hC0, LZB ? 8'h00 : 8'h3F, 8'h7C, 8'hBF, 8'h07, 8'h8E}};

        in_rst_n  = 1'b0;
        in_update = 1'b1;
        apply(vecs[0]);
        repeat (3) @(negedge in_clk);
        check("rst_enable", out_bus_enable, 0);
        check("rst_data", out_bus_data, 0);
        check("rst_busy", out_busy, 0);
        check("rst_done", out_frame_done, 0);
        log_q.delete();
        in_rst_n = 1'b1;

        // Table-driven frames; the first starts right after reset with the timer expired.
        for (int i = 0; i < 6; i++) begin
            apply(vecs[i]);
            log_q.delete();
            wait_done(1000, starts, first_rise, seen);
            check($sformatf("v%0d_done", i), seen, 1);
            check($sformatf("v%0d_starts", i), starts, 1);
            check($sformatf("v%0d_busy_at_done", i), out_busy, 0);
            check_frame($sformatf("v%0d", i), vecs[i].words);
            @(negedge in_clk);
            check($sformatf("v%0d_done_pulse", i), out_frame_done, 0);
        end

        // Inputs change mid-T2: current frame keeps the snapshot.
        tear = '{16'h0001, 4'b0000, 3'd2, 1'b1, 56'h0};
        apply(tear);
        log_q.delete();
        wait_log(2, 1000, ok);
        check("tear_reach_t2", ok, 1);
        in_digits = 16'hFFFF;
        wait_done(1000, starts, first_rise, seen);
        check("tear_done", seen, 1);
        check_frame("tear_cur", {8'h40, 8'hC0, LZB ? 8'h00 : 8'h3F, LZB ? 8'h00 : 8'h3F,
                                 LZB ? 8'h00 : 8'h3F, 8'h06, 8'h8A});
        log_q.delete();
        wait_done(1000, starts, first_rise, seen);
        check("tear_next_done", seen, 1);
        check_frame("tear_next", 56'h40_C0_71_71_71_71_8A);

        // in_update drops mid-frame: frame completes, then nothing until it returns.
        log_q.delete();
        wait_log(3, 1000, ok);
        check("upd_reach_t2", ok, 1);
        in_update = 1'b0;
        wait_done(1000, starts, first_rise, seen);
        check("upd_done", seen, 1);
        check_frame("upd", 56'h40_C0_71_71_71_71_8A);
        en_cnt = 0;
        for (int i = 0; i < 3 * PERIOD; i++) begin
            @(negedge in_clk);
            if (out_bus_enable || out_busy) en_cnt++;
        end
        check("upd_frozen", en_cnt, 0);
        log_q.delete();
        in_update = 1'b1;
        @(negedge in_clk);
        check("upd_restart", out_bus_enable, 1);
        check("upd_first_word", out_bus_data, 8'h40);

        // Asynchronous reset in T2 aborts; the next frame restarts from 0x40.
        wait_log(3, 1000, ok);
        check("rst_reach_t2", ok, 1);
        check("rst_t2_enable", out_bus_enable, 1);
        #2;
        in_rst_n = 1'b0;
        #1;
        check("arst_enable", out_bus_enable, 0);
        check("arst_data", out_bus_data, 0);
        check("arst_busy", out_busy, 0);
        repeat (4) @(negedge in_clk);
        log_q.delete();
        in_rst_n = 1'b1;
        wait_done(1000, starts, first_rise, seen);
        check("arst_done", seen, 1);
        check_frame("arst", 56'h40_C0_71_71_71_71_8A);

        // Slow bus: frames exceed the refresh period and run back to back.
        bus_delay = 500;
        apply(vecs[3]);
        log_q.delete();
        wait_done(6000, starts, first_rise, seen);
        check("ovr_a_done", seen, 1);
        check("ovr_a_starts", starts, 1);
        check_frame("ovr_a", vecs[3].words);
        log_q.delete();
        wait_done(6000, starts, first_rise, seen);
        check("ovr_b_done", seen, 1);
        check("ovr_b_starts", starts, 1);
        check("ovr_b_immediate", (first_rise >= 0) && (first_rise <= 2), 1);
        check_frame("ovr_b", vecs[3].words);
        bus_delay = 2;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
